// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
// Covers the occupancy encoding and the payload widths at each stage boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam int F2D_W = 64;
  localparam int D2E_W = 160;
  localparam int E2M_W = 104;
  localparam int M2W_W = 71;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// It is used as the optional stall counter of pipe_skid_reg.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_SKID_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = F2D_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PIPE_SKID_STALL_CNT_EN
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
`else
  output logic [DATA_W-1:0] out_data
`endif
);

  occ_e              state, next_state;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              in_fire, out_fire;
  logic              load_main_in, load_main_skid, load_skid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          next_state   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          next_state = TWO;
          load_skid  = 1'b1;
        end else if (out_fire) begin
          next_state = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          next_state     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // Handshake flags are registered from next_state so no combinational ready path crosses the stage.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= next_state;
      out_valid <= (next_state != EMPTY);
      in_ready  <= (next_state != TWO);
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  // Flush deliberately does not clear the stall count; only rst does.
  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid & ~out_ready),
    .count(stall_cnt)
  );
`endif

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Generic successor to the fixed fetch-to-decode style stage registers; replaces the enable/clear pair with backpressure plus flush.
- Sits between any two pipeline stages (F/D, D/E, E/M, M/W) and carries a packed payload bus.
- Registered in_ready, so stall paths do not ripple combinationally across stages.

Parameters:
- DATA_W, 64, payload width in bits (for F/D this is instr plus pc_plus_4).
- CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all held entries (replaces legacy clear).
- in_valid  in  1  upstream has payload.
- in_ready  out  1  stage can accept; registered.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  payload available to downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload to downstream; driven from main register.
- stall_cnt  out  CNT_W  present only with PIPE_SKID_STALL_CNT_EN.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Fires: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State: EMPTY (no entry), ONE (main valid), TWO (main + skid valid). out_valid = (state != EMPTY); in_ready = (state != TWO).
- Reset (rst=1 at clk edge): state EMPTY, main=0, skid=0, out_valid=0, in_ready=1, out_data=0. rst has highest priority, including mid-transfer.
- Flush (rst=0, flush=1): state EMPTY, main=0, skid=0. Any in_fire in the same cycle is dropped. out_fire in that cycle counts as consumed by downstream.
- EMPTY:
  - in_fire -> ONE, main<=in_data.
- ONE:
  - in_fire & out_fire -> ONE, main<=in_data.
  - in_fire & !out_fire -> TWO, skid<=in_data.
  - !in_fire & out_fire -> EMPTY.
  - otherwise hold.
- TWO (in_ready=0):
  - out_fire -> ONE, main<=skid.
  - otherwise hold.
- Latency: in_fire at edge N gives out_valid=1 after edge N, with out_data = that payload. Throughput is 1 transfer per cycle when out_ready=1.
- Ordering: strict FIFO; no payload is duplicated or lost except by flush.
- Data hold: on transition to EMPTY, main keeps its last value; out_data is don't-care while out_valid=0, except after rst/flush where it is 0.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- in_valid may drop without in_ready; no upstream stability rule is required of the block.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - Port stall_cnt exists; it increments each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst; flush does not clear it.
  - Counter updates in the same edge as the state update; reads are registered.
- Undefined: port and logic are absent; handshake behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - Occupancy state encoding: EMPTY=2'd0, ONE=2'd1, TWO=2'd2; 2'd3 is illegal and recovers to EMPTY.
  - Payload width constants for each stage boundary, e.g. F2D_W=64.
- Sub-module sat_counter (WIDTH param; clk, rst, inc, count) implements the optional stall counter.
- Everything else stays in pipe_skid_reg.

Test Plan:
- Reset: assert rst for 2 cycles while in_valid=1, in_data=64'hAAAA_0001 -> out_valid=0, in_ready=1, out_data=0; stall_cnt=0 if enabled.
- Streaming: out_ready=1, push 0x1..0x8 back-to-back -> out_data 0x1..0x8 each one cycle after its in_fire; in_ready stays 1 throughout.
- Backpressure: push 0xA, 0xB, 0xC with out_ready=0 -> 0xA in main, 0xB in skid, in_ready=0, 0xC held upstream. Then raise out_ready -> outputs 0xA, 0xB, 0xC in consecutive cycles.
- Flush in TWO with in_valid=1, in_data=0xD -> next cycle out_valid=0, out_data=0, in_ready=1, 0xD never appears at the output.
- Simultaneous fire in ONE (main=0x5, in_data=0x6, out_ready=1) -> stays ONE, out_data=0x6.
- PIPE_SKID_STALL_CNT_EN with CNT_W=2: hold out_valid=1, out_ready=0 for 6 cycles -> stall_cnt reads 1,2,3,3,3,3; a following flush leaves it at 3.
